instr_loader: RTL and testbench

Boot-time program loader sitting directly upstream of the single-cycle CPU. It accepts a byte stream over a valid/ready handshake: a length header, little-endian instruction words, then a checksum byte. It writes each assembled 32-bit word into instruction memory. After a verified load it raises the CPU start signal; on any error it holds the CPU in reset.

---
 rtl/instr_loader_pkg.sv | 32 +++
 rtl/instr_loader_word_assembler.sv | 71 +++++++
 rtl/instr_loader.sv | 167 ++++++++++++++++
 tb/tb_instr_loader.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_loader_pkg.sv
// -----------------------------------------------------------------------------
// instr_loader_pkg
// Shared definitions for the boot-time instruction loader:
//   - state_t      : loader FSM states
//   - HDR_BYTES    : bytes in the little-endian length header
//   - WORD_BYTES   : bytes per instruction word
//   - BYTE_CNT_W   : width of the within-word byte counter
//   - max_words()  : memory capacity in words, as a 17-bit value so that a
//                    16-bit length can be compared against it without overflow
// -----------------------------------------------------------------------------
package instr_loader_pkg;

  typedef enum logic [2:0] {
    ST_LEN0  = 3'd0,
    ST_LEN1  = 3'd1,
    ST_WORD  = 3'd2,
    ST_WRITE = 3'd3,
    ST_CSUM  = 3'd4,
    ST_DONE  = 3'd5,
    ST_ERR   = 3'd6
  } state_t;

  localparam int HDR_BYTES  = 2;
  localparam int WORD_BYTES = 4;
  localparam int BYTE_CNT_W = $clog2(WORD_BYTES);

  // Capacity 2**addr_w held in 17 bits: 2**16 still fits.
  function automatic logic [16:0] max_words(input int addr_w);
    return 17'(1) << addr_w;
  endfunction

endpackage

// File: rtl/instr_loader_word_assembler.sv
// -----------------------------------------------------------------------------
// word_assembler
// Shifts accepted stream bytes into a 32-bit word (first byte ends up in
// bits [7:0]), counts bytes within the word and keeps the running XOR of every
// byte it has accepted since the last clear.
// Ports:
//   clk_i        in   clock
//   rst_i        in   synchronous active-high reset
//   clear_i      in   synchronous clear of word, byte counter and checksum
//   accept_i     in   byte_i is consumed this cycle
//   byte_i       in   stream byte
//   word_o       out  assembled word (valid once four bytes have been taken)
//   word_full_o  out  this accept completes a word (combinational)
//   csum_o       out  running XOR of accepted bytes
// -----------------------------------------------------------------------------
module word_assembler
  import instr_loader_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clear_i,
  input  logic        accept_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_full_o,
  output logic [7:0]  csum_o
);

  logic [7:0]            r_lanes [WORD_BYTES];
  logic [BYTE_CNT_W-1:0] r_byte_cnt;
  logic [7:0]            r_csum;

  // Each lane takes the value of the lane above it; the top lane takes the
  // incoming byte. After four accepts the first byte sits in lane 0.
  genvar gi;
  generate
    for (gi = 0; gi < WORD_BYTES; gi++) begin : g_lane
      logic [7:0] w_lane_in;
      if (gi == WORD_BYTES - 1) begin : g_top
        assign w_lane_in = byte_i;
      end else begin : g_inner
        assign w_lane_in = r_lanes[gi+1];
      end

      always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
          r_lanes[gi] <= '0;
        end else if (accept_i) begin
          r_lanes[gi] <= w_lane_in;
        end
      end

      assign word_o[gi*8 +: 8] = r_lanes[gi];
    end
  endgenerate

  // The counter is exactly wide enough to wrap back to 0 after a full word.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      r_byte_cnt <= '0;
      r_csum     <= '0;
    end else if (accept_i) begin
      r_byte_cnt <= r_byte_cnt + BYTE_CNT_W'(1);
      r_csum     <= r_csum ^ byte_i;
    end
  end

  assign word_full_o = accept_i && (r_byte_cnt == BYTE_CNT_W'(WORD_BYTES - 1));
  assign csum_o      = r_csum;

endmodule

// File: rtl/instr_loader.sv
// -----------------------------------------------------------------------------
// instr_loader
// Boot-time program loader. Receives a byte stream (16-bit little-endian word
// count N, N little-endian 32-bit words, one XOR checksum over the data bytes)
// on a valid/ready handshake, writes each word into instruction memory and
// then either releases the CPU (DONE) or holds it in reset (ERR).
// Ports:
//   clk_i         in   clock, rising edge
//   rst_i         in   synchronous active-high reset
//   byte_i        in   stream byte
//   byte_valid_i  in   byte_i is valid
//   byte_ready_o  out  loader accepts a byte this cycle (LEN0/LEN1/WORD/CSUM)
//   reload_i      in   restart loading; only acted on in DONE or ERR
//   imem_we_o     out  instruction-memory write strobe, one cycle per word
//   imem_addr_o   out  byte address of the word being written
//   imem_data_o   out  word being written
//   cpu_start_o   out  CPU start / reset release
//   busy_o        out  load in progress
//   done_o        out  load verified
//   err_o         out  load failed
// -----------------------------------------------------------------------------
module instr_loader
  import instr_loader_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [7:0]  byte_i,
  input  logic        byte_valid_i,
  output logic        byte_ready_o,
  input  logic        reload_i,
  output logic        imem_we_o,
  output logic [31:0] imem_addr_o,
  output logic [31:0] imem_data_o,
  output logic        cpu_start_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o
);

  localparam logic [16:0] MAX_WORDS = max_words(ADDR_W);

  state_t                 r_state;
  state_t                 w_state_next;
  logic [ADDR_W:0]        r_word_cnt;
  logic [HDR_BYTES*8-1:0] r_n;
  logic                   r_imem_we;
  logic                   r_cpu_start;
  logic                   r_done;
  logic                   r_err;

  logic                   w_accept;
  logic                   w_clear;
  logic                   w_asm_accept;
  logic                   w_word_full;
  logic [31:0]            w_word;
  logic [7:0]             w_csum;
  logic [HDR_BYTES*8-1:0] w_n_full;
  logic [16:0]            w_cnt_inc;

  assign byte_ready_o = (r_state == ST_LEN0) || (r_state == ST_LEN1) ||
                        (r_state == ST_WORD) || (r_state == ST_CSUM);
  assign busy_o       = (r_state != ST_DONE) && (r_state != ST_ERR);

  assign w_accept     = byte_valid_i && byte_ready_o;
  assign w_clear      = reload_i && ((r_state == ST_DONE) || (r_state == ST_ERR));
  // Only data bytes go through the assembler, so the header never enters the
  // checksum and the checksum byte is never shifted into a word.
  assign w_asm_accept = w_accept && (r_state == ST_WORD);

  // Full length as it will be once the high header byte is latched; used to
  // decide the LEN1 exit in the same cycle the byte is accepted.
  assign w_n_full     = {byte_i, r_n[7:0]};
  assign w_cnt_inc    = 17'(r_word_cnt) + 17'd1;

  word_assembler u_asm (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .clear_i     (w_clear),
    .accept_i    (w_asm_accept),
    .byte_i      (byte_i),
    .word_o      (w_word),
    .word_full_o (w_word_full),
    .csum_o      (w_csum)
  );

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_LEN0: begin
        if (w_accept) w_state_next = ST_LEN1;
      end
      ST_LEN1: begin
        if (w_accept) begin
          if ({1'b0, w_n_full} > MAX_WORDS) begin
            w_state_next = ST_ERR;
          end else if (w_n_full == '0) begin
            w_state_next = ST_CSUM;
          end else begin
            w_state_next = ST_WORD;
          end
        end
      end
      ST_WORD: begin
        if (w_word_full) w_state_next = ST_WRITE;
      end
      ST_WRITE: begin
        if (w_cnt_inc == {1'b0, r_n}) begin
          w_state_next = ST_CSUM;
        end else begin
          w_state_next = ST_WORD;
        end
      end
      ST_CSUM: begin
        if (w_accept) begin
          w_state_next = (byte_i == w_csum) ? ST_DONE : ST_ERR;
        end
      end
      ST_DONE, ST_ERR: begin
        if (reload_i) w_state_next = ST_LEN0;
      end
      default: begin
        w_state_next = ST_LEN0;
      end
    endcase
  end

  // Status outputs are registered from the next state so they change on the
  // same edge as the state itself.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= ST_LEN0;
      r_word_cnt  <= '0;
      r_n         <= '0;
      r_imem_we   <= 1'b0;
      r_cpu_start <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_imem_we   <= (w_state_next == ST_WRITE);
      r_cpu_start <= (w_state_next == ST_DONE);
      r_done      <= (w_state_next == ST_DONE);
      r_err       <= (w_state_next == ST_ERR);
      if (w_clear) begin
        r_word_cnt <= '0;
        r_n        <= '0;
      end else begin
        // The address shown during WRITE is the pre-increment count.
        if (r_state == ST_WRITE) r_word_cnt <= w_cnt_inc[ADDR_W:0];
        if (w_accept && (r_state == ST_LEN0)) r_n[7:0] <= byte_i;
        if (w_accept && (r_state == ST_LEN1)) r_n <= w_n_full;
      end
    end
  end

  // The assembled word and the word counter are both flops and hold steady for
  // the whole WRITE cycle, so they drive the memory bus directly.
  assign imem_we_o   = r_imem_we;
  assign imem_addr_o = 32'({r_word_cnt, 2'b00});
  assign imem_data_o = w_word;
  assign cpu_start_o = r_cpu_start;
  assign done_o      = r_done;
  assign err_o       = r_err;

endmodule

// File: tb/tb_instr_loader.sv
`timescale 1ns/1ps
module tb_instr_loader;

  localparam int ADDR_W = 10;
  localparam int MAX_N  = 1 << ADDR_W;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic [7:0]  byte_i = 8'h00;
  logic        byte_valid_i = 1'b0;
  logic        byte_ready_o;
  logic        reload_i = 1'b0;
  logic        imem_we_o;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_data_o;
  logic        cpu_start_o;
  logic        busy_o;
  logic        done_o;
  logic        err_o;

  instr_loader #(.ADDR_W(ADDR_W)) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .byte_i       (byte_i),
    .byte_valid_i (byte_valid_i),
    .byte_ready_o (byte_ready_o),
    .reload_i     (reload_i),
    .imem_we_o    (imem_we_o),
    .imem_addr_o  (imem_addr_o),
    .imem_data_o  (imem_data_o),
    .cpu_start_o  (cpu_start_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .err_o        (err_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_data_q[$];
  logic [7:0]  stream_q[$];
  logic        exp_done;
  logic        exp_err;

  typedef struct {
    logic [127:0] bytes;      // byte k of the stream in bits [8k+7:8k]
    int           len;
    int           nw;
    logic [31:0]  last_addr;
    logic [31:0]  last_data;
    logic         done;
    logic         err;
  } vec_t;

  vec_t vecs[5];

  // Write monitor: records every write and checks the loader is not ready then.
  always @(negedge clk) begin
    if (imem_we_o === 1'b1) begin
      wr_addr_q.push_back(imem_addr_o);
      wr_data_q.push_back(imem_data_o);
      checks++;
      if (byte_ready_o !== 1'b0) begin
        errors++;
        $display("FAIL ready_during_write actual=%0b required=0", byte_ready_o);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0b required=%0b", name, act, req);
    end
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    byte_valid_i = 1'b0;
    reload_i = 1'b0;
    @(posedge clk); #1;
    rst_i = 1'b0;
    wr_addr_q.delete();
    wr_data_q.delete();
  endtask

  task automatic check_reset_values(input string tag);
    check1({tag, ":we"}, imem_we_o, 1'b0);
    check({tag, ":addr"}, imem_addr_o, 32'h0);
    check({tag, ":data"}, imem_data_o, 32'h0);
    check1({tag, ":cpu_start"}, cpu_start_o, 1'b0);
    check1({tag, ":done"}, done_o, 1'b0);
    check1({tag, ":err"}, err_o, 1'b0);
    check1({tag, ":busy"}, busy_o, 1'b1);
    check1({tag, ":ready"}, byte_ready_o, 1'b1);
  endtask

  task automatic do_reload();
    reload_i = 1'b1;
    @(posedge clk); #1;
    reload_i = 1'b0;
    check1("reload:busy", busy_o, 1'b1);
    check1("reload:cpu_start", cpu_start_o, 1'b0);
    wr_addr_q.delete();
    wr_data_q.delete();
  endtask

  // Offers every byte of stream_q in order with random idle gaps, holding each
  // byte until the loader takes it.
  task automatic send_stream(input int gap_max);
    for (int i = 0; i < stream_q.size(); i++) begin
      int k;
      int waited;
      bit took;
      k = int'($urandom_range(0, gap_max));
      byte_valid_i = 1'b0;
      repeat (k) begin
        byte_i = 8'($urandom);
        @(posedge clk); #1;
      end
      byte_valid_i = 1'b1;
      byte_i = stream_q[i];
      took = 1'b0;
      waited = 0;
      while (!took && waited < 64) begin
        took = (byte_ready_o === 1'b1);
        @(posedge clk); #1;
        waited++;
      end
      if (!took) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout byte_index=%0d actual=not_accepted required=accepted", i);
        byte_valid_i = 1'b0;
        return;
      end
    end
    byte_valid_i = 1'b0;
  endtask

  task automatic build_stream(input int n, input bit corrupt);
    logic [7:0] x;
    logic [7:0] b;
    stream_q.delete();
    x = 8'h00;
    stream_q.push_back(8'(n));
    stream_q.push_back(8'(n >> 8));
    if (n > MAX_N) return;
    for (int i = 0; i < 4 * n; i++) begin
      b = 8'($urandom);
      x ^= b;
      stream_q.push_back(b);
    end
    stream_q.push_back(corrupt ? (x ^ 8'(1 + $urandom_range(0, 254))) : x);
  endtask

  // Reference: parse the stream as header / words / checksum and list the
  // writes and final outcome it should produce.
  task automatic run_model();
    int n;
    logic [7:0]  x;
    logic [31:0] d;
    exp_addr_q.delete();
    exp_data_q.delete();
    n = int'({stream_q[1], stream_q[0]});
    if (n > MAX_N) begin
      exp_err = 1'b1;
      exp_done = 1'b0;
      return;
    end
    x = 8'h00;
    for (int w = 0; w < n; w++) begin
      d = 32'h0;
      for (int b = 0; b < 4; b++) begin
        d[8*b +: 8] = stream_q[2 + 4*w + b];
        x ^= stream_q[2 + 4*w + b];
      end
      exp_addr_q.push_back(32'(4 * w));
      exp_data_q.push_back(d);
    end
    exp_done = (stream_q[2 + 4*n] == x);
    exp_err  = !exp_done;
  endtask

  task automatic compare_run(input string tag);
    int m;
    repeat (2) begin @(posedge clk); #1; end
    check({tag, ":nwrites"}, 32'(wr_addr_q.size()), 32'(exp_addr_q.size()));
    m = (wr_addr_q.size() < exp_addr_q.size()) ? wr_addr_q.size() : exp_addr_q.size();
    for (int i = 0; i < m; i++) begin
      check($sformatf("%s:addr%0d", tag, i), wr_addr_q[i], exp_addr_q[i]);
      check($sformatf("%s:data%0d", tag, i), wr_data_q[i], exp_data_q[i]);
    end
    check1({tag, ":done"}, done_o, exp_done);
    check1({tag, ":err"}, err_o, exp_err);
    check1({tag, ":cpu_start"}, cpu_start_o, exp_done);
    check1({tag, ":busy"}, busy_o, 1'b0);
    $display("run %s: N=%0d writes=%0d done=%0b err=%0b", tag,
             int'({stream_q[1], stream_q[0]}), wr_addr_q.size(), done_o, err_o);
  endtask

  initial begin
    logic [7:0] sw [7];
    sw = '{8'h01, 8'h00, 8'h0A, 8'h00, 8'h08, 8'h20, 8'h22};

    vecs[0] = '{128'h22_20_08_00_0A_00_01, 7, 1, 32'h0, 32'h2008000A, 1'b1, 1'b0};
    vecs[1] = '{128'h00_00_00, 3, 0, 32'h0, 32'h0, 1'b1, 1'b0};
    vecs[2] = '{128'h23_20_08_00_0A_00_01, 7, 1, 32'h0, 32'h2008000A, 1'b0, 1'b1};
    vecs[3] = '{128'h04_01, 2, 0, 32'h0, 32'h0, 1'b0, 1'b1};
    vecs[4] = '{128'h88_88_77_66_55_44_33_22_11_00_02, 11, 2, 32'h4, 32'h88776655, 1'b1, 1'b0};

    // Power-on reset values.
    do_reset();
    check_reset_values("por");

    // Table-driven streams, each from a fresh reset.
    for (int i = 0; i < 5; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      do_reset();
      stream_q.delete();
      for (int k = 0; k < vecs[i].len; k++) stream_q.push_back(vecs[i].bytes[8*k +: 8]);
      send_stream(i % 2 == 0 ? 0 : 3);
      repeat (2) begin @(posedge clk); #1; end
      check({tag, ":nwrites"}, 32'(wr_addr_q.size()), 32'(vecs[i].nw));
      if (vecs[i].nw > 0 && wr_addr_q.size() > 0) begin
        check({tag, ":last_addr"}, wr_addr_q[wr_addr_q.size()-1], vecs[i].last_addr);
        check({tag, ":last_data"}, wr_data_q[wr_data_q.size()-1], vecs[i].last_data);
      end
      check1({tag, ":done"}, done_o, vecs[i].done);
      check1({tag, ":err"}, err_o, vecs[i].err);
      check1({tag, ":cpu_start"}, cpu_start_o, vecs[i].done);
      $display("vec %0d: writes=%0d done=%0b err=%0b", i, wr_addr_q.size(), done_o, err_o);
    end

    // Cycle-exact single word: write right after the 4th data byte, start two
    // cycles after the checksum byte is first offered.
    do_reset();
    for (int k = 0; k < 6; k++) begin
      byte_i = sw[k];
      byte_valid_i = 1'b1;
      @(posedge clk); #1;
    end
    check1("t:we", imem_we_o, 1'b1);
    check("t:addr", imem_addr_o, 32'h0);
    check("t:data", imem_data_o, 32'h2008000A);
    check1("t:ready_write", byte_ready_o, 1'b0);
    byte_i = sw[6];
    @(posedge clk); #1;
    check1("t:we_off", imem_we_o, 1'b0);
    check1("t:ready_csum", byte_ready_o, 1'b1);
    check1("t:cpu_start_early", cpu_start_o, 1'b0);
    @(posedge clk); #1;
    byte_valid_i = 1'b0;
    check1("t:cpu_start", cpu_start_o, 1'b1);
    check1("t:done", done_o, 1'b1);
    $display("timing: start seen two cycles after checksum offered");

    // Bad checksum, then reload and a good stream.
    do_reset();
    stream_q.delete();
    for (int k = 0; k < 7; k++) stream_q.push_back(sw[k]);
    stream_q[6] = 8'h23;
    run_model();
    send_stream(2);
    compare_run("badcsum");
    do_reload();
    stream_q[6] = 8'h22;
    run_model();
    send_stream(2);
    compare_run("after_reload");

    // Reload pulses during a load are ignored.
    do_reset();
    stream_q.delete();
    for (int k = 0; k < 7; k++) stream_q.push_back(sw[k]);
    run_model();
    byte_i = sw[0];
    byte_valid_i = 1'b1;
    @(posedge clk); #1;
    byte_valid_i = 1'b0;
    reload_i = 1'b1;
    @(posedge clk); #1;
    reload_i = 1'b0;
    void'(stream_q.pop_front());
    send_stream(1);
    stream_q.push_front(sw[0]);
    compare_run("reload_ignored");

    // Reset in the middle of word 1, then a clean load.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      byte_i = sw[k];
      byte_valid_i = 1'b1;
      @(posedge clk); #1;
    end
    byte_valid_i = 1'b0;
    do_reset();
    check_reset_values("midreset");
    stream_q.delete();
    for (int k = 0; k < 7; k++) stream_q.push_back(sw[k]);
    run_model();
    send_stream(1);
    compare_run("after_midreset");

    // Full memory: N == 2**ADDR_W.
    do_reset();
    build_stream(MAX_N, 1'b0);
    run_model();
    send_stream(0);
    compare_run("full");
    if (wr_addr_q.size() > 0) check("full:last_addr", wr_addr_q[wr_addr_q.size()-1], 32'hFFC);

    // Random streams, chained with reload.
    do_reset();
    for (int it = 0; it < 16; it++) begin
      int n;
      bit corrupt;
      if ($urandom_range(0, 7) == 0) n = int'($urandom_range(MAX_N + 1, 65535));
      else n = int'($urandom_range(0, 6));
      corrupt = ($urandom_range(0, 3) == 0);
      build_stream(n, corrupt);
      run_model();
      send_stream(3);
      compare_run($sformatf("rand%0d", it));
      do_reload();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
